// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_unit
//  Description : Hazard detection and forwarding control for a 5-stage
//                in-order pipeline. A 2-entry scoreboard tracks the
//                destinations of the instructions in EX (S0) and MEM (S1).
//                It is used to raise a stall for the instruction in ID, a
//                flush on a taken branch, and registered EX operand-forward
//                selects. Stall and flush cycles are counted by saturating
//                performance counters.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Configuration macro:
//    PIPE_HAZARD_FORWARD_EN  defined   : forwarding on. Only a load-use
//                                        dependency on the EX occupant stalls
//                                        (1 cycle).
//                            undefined : no forwarding. Any dependency on the
//                                        EX or MEM occupant stalls (up to
//                                        2 cycles). fwd_a_o/fwd_b_o read 00.
// ----------------------------------------------------------------------------
//  Ports:
//    clk_i           in   1       clock, rising edge
//    rst_i           in   1       asynchronous reset, active low
//    id_valid_i      in   1       valid instruction in ID
//    id_rs_i/id_rt_i in   REG_AW  ID source register addresses
//    id_rs_use_i     in   1       ID instruction reads rs
//    id_rt_use_i     in   1       ID instruction reads rt
//    id_rd_i         in   REG_AW  ID destination register (after RegDst)
//    id_regwrite_i   in   1       ID instruction writes the register file
//    id_memread_i    in   1       ID instruction is a load
//    branch_taken_i  in   1       branch in MEM is taken
//    stall_o         out  1       hold PC and IF/ID, bubble into ID/EX
//    flush_o         out  1       kill IF/ID, ID/EX and EX/MEM
//    fwd_a_o/fwd_b_o out  2       EX operand select (00 RF, 01 EX/MEM,
//                                 10 MEM/WB)
//    stall_cnt_o     out  CNT_W   saturating count of stall cycles
//    flush_cnt_o     out  CNT_W   saturating count of flush cycles
// ============================================================================
module pipe_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_rs_use_i,
    input  logic              id_rt_use_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              branch_taken_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam logic [REG_AW-1:0] c_reg_zero = '0;
    localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_cnt_max  = '1;

    // ------------------------------------------------------------------
    // Scoreboard: S0 = EX occupant, S1 = MEM occupant
    // ------------------------------------------------------------------
    logic              r_s0_valid;
    logic [REG_AW-1:0] r_s0_rd;
    logic              r_s0_regwrite;
    logic              r_s0_memread;
    logic              r_s1_valid;
    logic [REG_AW-1:0] r_s1_rd;
    logic              r_s1_regwrite;
    logic              r_s1_memread;

    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_a_s0;
    logic w_b_s0;
    logic w_a_s1;
    logic w_b_s1;
    logic w_hazard;
    logic w_stall;
    logic w_flush;

    // A load's memread bit is only consulted while it sits in EX; the MEM
    // copy is carried for completeness of the entry.
    logic w_unused_s1_memread;
    assign w_unused_s1_memread = r_s1_memread;

    // Producer matches. Writes to register 0 never create a dependency.
    assign w_a_s0 = r_s0_valid & r_s0_regwrite & (r_s0_rd != c_reg_zero)
                  & (r_s0_rd == id_rs_i) & id_rs_use_i;
    assign w_b_s0 = r_s0_valid & r_s0_regwrite & (r_s0_rd != c_reg_zero)
                  & (r_s0_rd == id_rt_i) & id_rt_use_i;
    assign w_a_s1 = r_s1_valid & r_s1_regwrite & (r_s1_rd != c_reg_zero)
                  & (r_s1_rd == id_rs_i) & id_rs_use_i;
    assign w_b_s1 = r_s1_valid & r_s1_regwrite & (r_s1_rd != c_reg_zero)
                  & (r_s1_rd == id_rt_i) & id_rt_use_i;

`ifdef PIPE_HAZARD_FORWARD_EN
    // With forwarding, only a load in EX cannot supply its result in time.
    assign w_hazard = r_s0_memread & (w_a_s0 | w_b_s0);
`else
    assign w_hazard = w_a_s0 | w_b_s0 | w_a_s1 | w_b_s1;
`endif

    // Both strobes are forced low while reset is held. A taken branch
    // wins over a stall since the stalled instruction is being killed.
    assign w_flush = rst_i & branch_taken_i;
    assign w_stall = rst_i & id_valid_i & ~branch_taken_i & w_hazard;

    assign stall_o = w_stall;
    assign flush_o = w_flush;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_s0_valid    <= 1'b0;
            r_s0_rd       <= '0;
            r_s0_regwrite <= 1'b0;
            r_s0_memread  <= 1'b0;
            r_s1_valid    <= 1'b0;
            r_s1_rd       <= '0;
            r_s1_regwrite <= 1'b0;
            r_s1_memread  <= 1'b0;
        end else if (w_flush) begin
            // The EX occupant (moving to MEM) and the ID occupant are killed.
            r_s0_valid    <= 1'b0;
            r_s0_rd       <= '0;
            r_s0_regwrite <= 1'b0;
            r_s0_memread  <= 1'b0;
            r_s1_valid    <= 1'b0;
            r_s1_rd       <= '0;
            r_s1_regwrite <= 1'b0;
            r_s1_memread  <= 1'b0;
        end else begin
            r_s1_valid    <= r_s0_valid;
            r_s1_rd       <= r_s0_rd;
            r_s1_regwrite <= r_s0_regwrite;
            r_s1_memread  <= r_s0_memread;
            if (w_stall) begin
                r_s0_valid    <= 1'b0;
                r_s0_rd       <= '0;
                r_s0_regwrite <= 1'b0;
                r_s0_memread  <= 1'b0;
            end else begin
                r_s0_valid    <= id_valid_i;
                r_s0_rd       <= id_rd_i;
                r_s0_regwrite <= id_regwrite_i;
                r_s0_memread  <= id_memread_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Forward selects, registered on the edge that moves ID into EX
    // ------------------------------------------------------------------
`ifdef PIPE_HAZARD_FORWARD_EN
    logic       w_bubble;
    logic [1:0] w_fwd_a_nxt;
    logic [1:0] w_fwd_b_nxt;
    logic [1:0] r_fwd_a;
    logic [1:0] r_fwd_b;

    assign w_bubble = w_stall | w_flush | ~id_valid_i;

    // The nearer producer (EX/MEM) holds the newer value, so it wins.
    always_comb begin
        w_fwd_a_nxt = 2'b00;
        w_fwd_b_nxt = 2'b00;
        if (!w_bubble) begin
            if (w_a_s0) begin
                w_fwd_a_nxt = 2'b01;
            end else if (w_a_s1) begin
                w_fwd_a_nxt = 2'b10;
            end
            if (w_b_s0) begin
                w_fwd_b_nxt = 2'b01;
            end else if (w_b_s1) begin
                w_fwd_b_nxt = 2'b10;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_fwd_a <= 2'b00;
            r_fwd_b <= 2'b00;
        end else begin
            r_fwd_a <= w_fwd_a_nxt;
            r_fwd_b <= w_fwd_b_nxt;
        end
    end

    assign fwd_a_o = r_fwd_a;
    assign fwd_b_o = r_fwd_b;
`else
    assign fwd_a_o = 2'b00;
    assign fwd_b_o = 2'b00;
`endif

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (w_flush && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_unit
//  Description : Self-checking bench for pipe_hazard_unit. Directed
//                scenarios plus a randomized run against a reference model
//                that tracks the instructions in flight after ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_unit;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              id_valid_i = 1'b0;
    logic [REG_AW-1:0] id_rs_i = '0;
    logic [REG_AW-1:0] id_rt_i = '0;
    logic              id_rs_use_i = 1'b0;
    logic              id_rt_use_i = 1'b0;
    logic [REG_AW-1:0] id_rd_i = '0;
    logic              id_regwrite_i = 1'b0;
    logic              id_memread_i = 1'b0;
    logic              branch_taken_i = 1'b0;
    logic              stall_o;
    logic              flush_o;
    logic [1:0]        fwd_a_o;
    logic [1:0]        fwd_b_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    pipe_hazard_unit #(
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .id_valid_i     (id_valid_i),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .id_rs_use_i    (id_rs_use_i),
        .id_rt_use_i    (id_rt_use_i),
        .id_rd_i        (id_rd_i),
        .id_regwrite_i  (id_regwrite_i),
        .id_memread_i   (id_memread_i),
        .branch_taken_i (branch_taken_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .fwd_a_o        (fwd_a_o),
        .fwd_b_o        (fwd_b_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // ------------------------------------------------------------------
    // Reference model: list of instructions past ID, index 0 = EX, 1 = MEM
    // ------------------------------------------------------------------
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              rw;
        logic              mr;
    } instr_t;

    localparam instr_t BUBBLE = '{valid: 1'b0, rd: '0, rw: 1'b0, mr: 1'b0};

    instr_t     inflight[$];
    logic       exp_stall;
    logic       exp_flush;
    logic [1:0] exp_fwd_a;
    logic [1:0] exp_fwd_b;
    int         exp_stall_cnt;
    int         exp_flush_cnt;

    function automatic bit produces(instr_t p, logic [REG_AW-1:0] src, logic use_bit);
        return p.valid && p.rw && (p.rd != 0) && (p.rd == src) && use_bit;
    endfunction

    // Nearest older producer supplies the value: age 0 -> EX/MEM, age 1 -> MEM/WB.
    function automatic logic [1:0] fwd_source(logic [REG_AW-1:0] src, logic use_bit);
`ifdef PIPE_HAZARD_FORWARD_EN
        for (int k = 0; k < inflight.size(); k++) begin
            if (produces(inflight[k], src, use_bit)) return (k == 0) ? 2'b01 : 2'b10;
        end
`endif
        return 2'b00;
    endfunction

    function automatic bit model_hazard();
`ifdef PIPE_HAZARD_FORWARD_EN
        return inflight[0].mr &&
               (produces(inflight[0], id_rs_i, id_rs_use_i) ||
                produces(inflight[0], id_rt_i, id_rt_use_i));
`else
        for (int k = 0; k < inflight.size(); k++) begin
            if (produces(inflight[k], id_rs_i, id_rs_use_i) ||
                produces(inflight[k], id_rt_i, id_rt_use_i)) return 1'b1;
        end
        return 1'b0;
`endif
    endfunction

    task automatic reset_model();
        inflight = '{BUBBLE, BUBBLE};
        exp_stall = 1'b0;
        exp_flush = 1'b0;
        exp_fwd_a = 2'b00;
        exp_fwd_b = 2'b00;
        exp_stall_cnt = 0;
        exp_flush_cnt = 0;
    endtask

    task automatic set_idle();
        id_valid_i = 1'b0; id_rs_i = '0; id_rt_i = '0; id_rs_use_i = 1'b0;
        id_rt_use_i = 1'b0; id_rd_i = '0; id_regwrite_i = 1'b0;
        id_memread_i = 1'b0; branch_taken_i = 1'b0;
    endtask

    // Drive the ID-stage inputs and work out the expected strobes.
    task automatic apply(input logic v, input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                         input logic rs_u, input logic rt_u, input logic [REG_AW-1:0] rd,
                         input logic rw, input logic mr, input logic br);
        id_valid_i = v; id_rs_i = rs; id_rt_i = rt; id_rs_use_i = rs_u;
        id_rt_use_i = rt_u; id_rd_i = rd; id_regwrite_i = rw;
        id_memread_i = mr; branch_taken_i = br;
        exp_flush = br;
        exp_stall = v && !br && model_hazard();
        #1;
    endtask

    // Advance the model by one clock, then let the DUT take the same edge.
    task automatic tick();
        instr_t issued;
        if (!exp_flush && !exp_stall && id_valid_i) begin
            exp_fwd_a = fwd_source(id_rs_i, id_rs_use_i);
            exp_fwd_b = fwd_source(id_rt_i, id_rt_use_i);
        end else begin
            exp_fwd_a = 2'b00;
            exp_fwd_b = 2'b00;
        end
        issued = '{valid: id_valid_i, rd: id_rd_i, rw: id_regwrite_i, mr: id_memread_i};
        if (exp_flush) begin
            inflight = '{BUBBLE, BUBBLE};
        end else begin
            inflight.push_front(exp_stall ? BUBBLE : issued);
            void'(inflight.pop_back());
        end
        if (exp_stall && exp_stall_cnt < CNT_MAX) exp_stall_cnt++;
        if (exp_flush && exp_flush_cnt < CNT_MAX) exp_flush_cnt++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        reset_model();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        set_idle();
        rst_i = 1'b0;
        id_valid_i = 1'b1;
        branch_taken_i = 1'b1;
        @(posedge clk_i);
        #2;
        n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %0b want 0", stall_o); end
        n_checks++; if (flush_o !== 1'b0) begin n_errors++; $display("FAIL reset_flush: got %0b want 0", flush_o); end
        n_checks++; if (fwd_a_o !== 2'b00 || fwd_b_o !== 2'b00) begin n_errors++; $display("FAIL reset_fwd: got %b/%b want 00/00", fwd_a_o, fwd_b_o); end
        n_checks++; if (stall_cnt_o !== '0 || flush_cnt_o !== '0) begin n_errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt_o, flush_cnt_o); end
        do_reset();
    endtask

    task automatic test_alu_forward();
        do_reset();
        apply(1, 0, 0, 0, 0, 3, 1, 0, 0);     // ALU write to $3
        tick();
        apply(1, 3, 0, 1, 0, 4, 1, 0, 0);     // consumer reads rs=$3
`ifdef PIPE_HAZARD_FORWARD_EN
        n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL alu_stall: got %0b want 0", stall_o); end
        tick();
        n_checks++; if (fwd_a_o !== 2'b01) begin n_errors++; $display("FAIL alu_fwd_a: got %b want 01", fwd_a_o); end
        n_checks++; if (stall_cnt_o !== 4'd0) begin n_errors++; $display("FAIL alu_stall_cnt: got %0d want 0", stall_cnt_o); end
`else
        for (int c = 0; c < 2; c++) begin
            n_checks++; if (stall_o !== 1'b1) begin n_errors++; $display("FAIL alu_stall_c%0d: got %0b want 1", c, stall_o); end
            tick();
            apply(1, 3, 0, 1, 0, 4, 1, 0, 0);
        end
        n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL alu_stall_end: got %0b want 0", stall_o); end
        tick();
        n_checks++; if (fwd_a_o !== 2'b00) begin n_errors++; $display("FAIL alu_fwd_a: got %b want 00", fwd_a_o); end
        n_checks++; if (stall_cnt_o !== 4'd2) begin n_errors++; $display("FAIL alu_stall_cnt: got %0d want 2", stall_cnt_o); end
`endif
    endtask

    task automatic test_load_use();
        do_reset();
        apply(1, 0, 0, 0, 0, 2, 1, 1, 0);     // lw $2
        tick();
        apply(1, 0, 2, 0, 1, 6, 1, 0, 0);     // consumer reads rt=$2
        n_checks++; if (stall_o !== 1'b1) begin n_errors++; $display("FAIL lu_stall_first: got %0b want 1", stall_o); end
        tick();
        apply(1, 0, 2, 0, 1, 6, 1, 0, 0);
`ifdef PIPE_HAZARD_FORWARD_EN
        n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL lu_stall_second: got %0b want 0", stall_o); end
        tick();
        n_checks++; if (fwd_b_o !== 2'b10) begin n_errors++; $display("FAIL lu_fwd_b: got %b want 10", fwd_b_o); end
        n_checks++; if (stall_cnt_o !== 4'd1) begin n_errors++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt_o); end
`else
        n_checks++; if (stall_o !== 1'b1) begin n_errors++; $display("FAIL lu_stall_second: got %0b want 1", stall_o); end
        tick();
        apply(1, 0, 2, 0, 1, 6, 1, 0, 0);
        n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL lu_stall_third: got %0b want 0", stall_o); end
        tick();
        n_checks++; if (fwd_b_o !== 2'b00) begin n_errors++; $display("FAIL lu_fwd_b: got %b want 00", fwd_b_o); end
        n_checks++; if (stall_cnt_o !== 4'd2) begin n_errors++; $display("FAIL lu_stall_cnt: got %0d want 2", stall_cnt_o); end
`endif
    endtask

    task automatic test_zero_reg();
        do_reset();
        apply(1, 0, 0, 0, 0, 0, 1, 1, 0);     // load writing $0
        tick();
        apply(1, 0, 0, 1, 1, 7, 1, 0, 0);     // consumer reads $0 twice
        n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL zero_stall: got %0b want 0", stall_o); end
        tick();
        n_checks++; if (fwd_a_o !== 2'b00 || fwd_b_o !== 2'b00) begin n_errors++; $display("FAIL zero_fwd: got %b/%b want 00/00", fwd_a_o, fwd_b_o); end
    endtask

    task automatic test_branch_flush();
        do_reset();
        apply(1, 0, 0, 0, 0, 2, 1, 1, 0);     // lw $2
        tick();
        apply(1, 0, 2, 0, 1, 6, 1, 0, 1);     // load-use plus taken branch
        n_checks++; if (flush_o !== 1'b1) begin n_errors++; $display("FAIL br_flush: got %0b want 1", flush_o); end
        n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL br_stall: got %0b want 0", stall_o); end
        tick();
        n_checks++; if (flush_cnt_o !== 4'd1 || stall_cnt_o !== 4'd0) begin n_errors++; $display("FAIL br_cnt: got flush %0d stall %0d want 1/0", flush_cnt_o, stall_cnt_o); end
        apply(1, 0, 2, 0, 1, 6, 1, 0, 0);     // $2 producer was killed
        n_checks++; if (stall_o !== 1'b0 || flush_o !== 1'b0) begin n_errors++; $display("FAIL br_bubbled: got stall %0b flush %0b want 0/0", stall_o, flush_o); end
        tick();
        n_checks++; if (fwd_b_o !== 2'b00) begin n_errors++; $display("FAIL br_fwd_b: got %b want 00", fwd_b_o); end
    endtask

    task automatic test_reset_mid_stall();
        bit found;
        do_reset();
        apply(1, 0, 0, 0, 0, 2, 1, 1, 0);     // lw $2
        tick();
        apply(1, 0, 2, 0, 1, 2, 1, 1, 0);     // lw $2,0($2): stalls
        tick();
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            apply(1, 0, 2, 0, 1, 2, 1, 1, 0);
            if (stall_o === 1'b1) found = 1'b1;
            else tick();
        end
        n_checks++; if (!found) begin n_errors++; $display("FAIL rst_mid_find_stall: got no stall within 4 cycles want stall"); end
        n_checks++; if (stall_cnt_o !== CNT_W'(exp_stall_cnt)) begin n_errors++; $display("FAIL rst_mid_precnt: got %0d want %0d", stall_cnt_o, exp_stall_cnt); end
        branch_taken_i = 1'b1;
        rst_i = 1'b0;
        #1;
        n_checks++; if (stall_o !== 1'b0 || flush_o !== 1'b0) begin n_errors++; $display("FAIL rst_mid_strobes: got stall %0b flush %0b want 0/0", stall_o, flush_o); end
        n_checks++; if (stall_cnt_o !== '0 || flush_cnt_o !== '0) begin n_errors++; $display("FAIL rst_mid_cnt: got %0d/%0d want 0/0", stall_cnt_o, flush_cnt_o); end
        n_checks++; if (fwd_a_o !== 2'b00 || fwd_b_o !== 2'b00) begin n_errors++; $display("FAIL rst_mid_fwd: got %b/%b want 00/00", fwd_a_o, fwd_b_o); end
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        reset_model();
        apply(1, 0, 2, 0, 1, 6, 1, 0, 0);     // scoreboard must be empty now
        n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL rst_mid_after: got stall %0b want 0", stall_o); end
        tick();
    endtask

    task automatic test_random();
        logic              v, rs_u, rt_u, rw, mr, br;
        logic [REG_AW-1:0] rs, rt, rd;
        do_reset();
        v = 0; rs = 0; rt = 0; rs_u = 0; rt_u = 0; rd = 0; rw = 0; mr = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            // A stalled instruction stays in ID until it can issue.
            if (!exp_stall || cyc == 0) begin
                v    = ($urandom_range(0, 99) < 85);
                rs   = REG_AW'($urandom_range(0, 3));
                rt   = REG_AW'($urandom_range(0, 3));
                rs_u = $urandom_range(0, 1);
                rt_u = $urandom_range(0, 1);
                rd   = REG_AW'($urandom_range(0, 3));
                rw   = ($urandom_range(0, 99) < 75);
                mr   = rw && ($urandom_range(0, 99) < 40);
            end
            br = ($urandom_range(0, 99) < 10);
            apply(v, rs, rt, rs_u, rt_u, rd, rw, mr, br);
            n_checks++; if (stall_o !== exp_stall || flush_o !== exp_flush) begin n_errors++; $display("FAIL rnd_strobes c%0d: got stall %0b flush %0b want %0b/%0b", cyc, stall_o, flush_o, exp_stall, exp_flush); end
            tick();
            n_checks++; if (fwd_a_o !== exp_fwd_a || fwd_b_o !== exp_fwd_b) begin n_errors++; $display("FAIL rnd_fwd c%0d: got %b/%b want %b/%b", cyc, fwd_a_o, fwd_b_o, exp_fwd_a, exp_fwd_b); end
            n_checks++; if (stall_cnt_o !== CNT_W'(exp_stall_cnt) || flush_cnt_o !== CNT_W'(exp_flush_cnt)) begin n_errors++; $display("FAIL rnd_cnt c%0d: got %0d/%0d want %0d/%0d", cyc, stall_cnt_o, flush_cnt_o, exp_stall_cnt, exp_flush_cnt); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_model();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_zero_reg();
        test_branch_flush();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
